// File: rtl/tft_pkg.sv
// Shared definitions for the TFT parallel read engine.
// Contents:
//   - default phase lengths in CLOCK cycles (50 MHz, 20 ns per cycle)
//   - the FSM state encoding
//   - the bit positions inside the two-bit call request
//   - a helper that tells which states are timed by the phase counter
package tft_pkg;

  // Phase lengths in CLOCK cycles.
  localparam logic [7:0] TCSL_DEF  = 8'd3;   // index phase, CS_N low  (60 ns)
  localparam logic [7:0] TCSH_DEF  = 8'd25;  // index phase, CS_N high (500 ns)
  localparam logic [7:0] TTURN_DEF = 8'd2;   // bus turnaround, no strobes
  localparam logic [7:0] TRDL_DEF  = 8'd25;  // read strobe low (500 ns)
  localparam logic [7:0] TRDH_DEF  = 8'd25;  // read strobe high / recovery

  // Bit positions inside the call request.
  localparam int CALL_IDX = 1;  // index write followed by a data read
  localparam int CALL_RD  = 0;  // data read only

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_IDX_L = 3'd1,
    ST_IDX_H = 3'd2,
    ST_TURN  = 3'd3,
    ST_RD_L  = 3'd4,
    ST_RD_H  = 3'd5,
    ST_DONE  = 3'd6,
    ST_FIN   = 3'd7
  } tft_state_e;

  // States whose duration comes from the phase counter; only these can be
  // aborted by the caller dropping its request.
  function automatic logic is_timed(input tft_state_e s);
    return (s == ST_IDX_L) || (s == ST_IDX_H) || (s == ST_TURN) ||
           (s == ST_RD_L)  || (s == ST_RD_H);
  endfunction

endpackage

// File: rtl/tft_phase_cnt.sv
// Phase counter for the TFT read engine.
// Counts CLOCK cycles spent in the current phase and flags the final cycle.
// Ports:
//   CLOCK  in   system clock
//   RESET  in   synchronous active-high reset
//   clear  in   restart the count at zero on the next edge
//   len    in   8   length of the current phase in cycles (>= 1)
//   count  out  8   cycles already spent in the phase (0-based)
//   last   out  1   high while count == len-1
module tft_phase_cnt (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       clear,
  input  logic [7:0] len,
  output logic [7:0] count,
  output logic       last
);

  logic [7:0] count_reg;

  always_ff @(posedge CLOCK) begin
    if (RESET || clear) begin
      count_reg <= 8'd0;
    end else begin
      count_reg <= count_reg + 8'd1;
    end
  end

  assign count = count_reg;
  assign last  = (count_reg == (len - 8'd1));

endmodule

// File: rtl/tft_readmod.sv
// 8080-style parallel read engine for an ILI932x-class TFT controller.
// Performs either an index write followed by a data read, or a data read
// alone, and owns the tristate enable of the shared data bus.
// Ports:
//   CLOCK       in   1   system clock
//   RESET       in   1   synchronous active-high reset
//   iCall       in   2   [1] index+read, [0] read only; held until oDone
//   oDone       out  1   one-cycle completion pulse
//   iAddr       in   8   register index used by the index phase
//   oData       out  16  last captured read word
//   TFT_RS      out  1   1 = data, 0 = command/index
//   TFT_CS_N    out  1   chip select, active low
//   TFT_WR_N    out  1   write strobe, active low
//   TFT_RD_N    out  1   read strobe, active low
//   TFT_DB_OUT  out  16  value driven onto the bus
//   TFT_DB_OE   out  1   1 = drive the bus with TFT_DB_OUT
//   TFT_DB_IN   in   16  bus sample from the pad
// Every pin output is a flop loaded from the pin values of the next state,
// so the pins change on the same edge as the state and nothing on the pins
// is combinational from iCall.
module tft_readmod
  import tft_pkg::*;
#(
  parameter logic [7:0] TCSL  = TCSL_DEF,
  parameter logic [7:0] TCSH  = TCSH_DEF,
  parameter logic [7:0] TTURN = TTURN_DEF,
  parameter logic [7:0] TRDL  = TRDL_DEF,
  parameter logic [7:0] TRDH  = TRDH_DEF
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [1:0]  iCall,
  output logic        oDone,
  input  logic [7:0]  iAddr,
  output logic [15:0] oData,
  output logic        TFT_RS,
  output logic        TFT_CS_N,
  output logic        TFT_WR_N,
  output logic        TFT_RD_N,
  output logic [15:0] TFT_DB_OUT,
  output logic        TFT_DB_OE,
  input  logic [15:0] TFT_DB_IN
);

  tft_state_e state_reg, state_next;

  logic [7:0] phase_len;
  logic [7:0] phase_count;
  logic       phase_last;
  logic       phase_clear;
  logic       capture;

  logic        rs_reg,   rs_next;
  logic        cs_n_reg, cs_n_next;
  logic        wr_n_reg, wr_n_next;
  logic        rd_n_reg, rd_n_next;
  logic        oe_reg,   oe_next;
  logic        done_reg, done_next;
  logic [15:0] db_out_reg, db_out_next;
  logic [15:0] data_reg;

  // Length of the phase the FSM is currently in.
  always_comb begin
    phase_len = 8'd1;
    case (state_reg)
      ST_IDX_L: phase_len = TCSL;
      ST_IDX_H: phase_len = TCSH;
      ST_TURN:  phase_len = TTURN;
      ST_RD_L:  phase_len = TRDL;
      ST_RD_H:  phase_len = TRDH;
      default:  phase_len = 8'd1;
    endcase
  end

  // Restart the count on every state change and keep it at zero while idle.
  assign phase_clear = (state_next != state_reg) || (state_next == ST_IDLE);

  tft_phase_cnt u_phase_cnt (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .clear (phase_clear),
    .len   (phase_len),
    .count (phase_count),
    .last  (phase_last)
  );

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (iCall[CALL_IDX])     state_next = ST_IDX_L;
        else if (iCall[CALL_RD]) state_next = ST_TURN;
      end
      ST_IDX_L: if (phase_last) state_next = ST_IDX_H;
      ST_IDX_H: if (phase_last) state_next = ST_TURN;
      ST_TURN:  if (phase_last) state_next = ST_RD_L;
      ST_RD_L:  if (phase_last) state_next = ST_RD_H;
      ST_RD_H:  if (phase_last) state_next = ST_DONE;
      ST_DONE:  state_next = ST_FIN;
      ST_FIN:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    // A withdrawn request abandons any timed phase immediately.
    if (is_timed(state_reg) && (iCall == 2'b00)) begin
      state_next = ST_IDLE;
    end
  end

  // Capture only when the read strobe phase completes normally, so an abort
  // on the final strobe cycle leaves oData untouched.
  assign capture = (state_reg == ST_RD_L) && (state_next == ST_RD_H);

  // Pin values belonging to the state being entered.
  always_comb begin
    rs_next     = 1'b1;
    cs_n_next   = 1'b1;
    wr_n_next   = 1'b1;
    rd_n_next   = 1'b1;
    oe_next     = 1'b0;
    done_next   = 1'b0;
    db_out_next = 16'h0000;
    case (state_next)
      ST_IDX_L: begin
        rs_next     = 1'b0;
        cs_n_next   = 1'b0;
        wr_n_next   = 1'b0;
        oe_next     = 1'b1;
        db_out_next = {8'h00, iAddr};
      end
      ST_IDX_H: begin
        // Keep the index on the bus through the CS_N rise the panel latches on.
        rs_next     = 1'b0;
        wr_n_next   = 1'b0;
        oe_next     = 1'b1;
        db_out_next = db_out_reg;
      end
      ST_RD_L: begin
        cs_n_next = 1'b0;
        rd_n_next = 1'b0;
      end
      ST_DONE: begin
        done_next = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_reg  <= ST_IDLE;
      rs_reg     <= 1'b1;
      cs_n_reg   <= 1'b1;
      wr_n_reg   <= 1'b1;
      rd_n_reg   <= 1'b1;
      oe_reg     <= 1'b0;
      done_reg   <= 1'b0;
      db_out_reg <= 16'h0000;
      data_reg   <= 16'h0000;
    end else begin
      state_reg  <= state_next;
      rs_reg     <= rs_next;
      cs_n_reg   <= cs_n_next;
      wr_n_reg   <= wr_n_next;
      rd_n_reg   <= rd_n_next;
      oe_reg     <= oe_next;
      done_reg   <= done_next;
      db_out_reg <= db_out_next;
      // The pad value has settled for most of the strobe by this edge, so no
      // synchroniser is needed.
      if (capture) begin
        data_reg <= TFT_DB_IN;
      end
    end
  end

  assign TFT_RS     = rs_reg;
  assign TFT_CS_N   = cs_n_reg;
  assign TFT_WR_N   = wr_n_reg;
  assign TFT_RD_N   = rd_n_reg;
  assign TFT_DB_OE  = oe_reg;
  assign TFT_DB_OUT = db_out_reg;
  assign oDone      = done_reg;
  assign oData      = data_reg;

  // The count itself is only consumed through the last-cycle flag.
  logic unused_ok;
  assign unused_ok = ^phase_count;

endmodule

// File: tb/tb_tft_readmod.sv
module tb_tft_readmod;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic [1:0]  iCall = 2'b00;
  logic [7:0]  iAddr = 8'h00;
  logic [15:0] TFT_DB_IN = 16'h0000;
  logic        oDone;
  logic [15:0] oData;
  logic        TFT_RS, TFT_CS_N, TFT_WR_N, TFT_RD_N, TFT_DB_OE;
  logic [15:0] TFT_DB_OUT;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] data;
    int          lat;
  } exp_t;
  exp_t sb[$];

  tft_readmod dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .iCall      (iCall),
    .oDone      (oDone),
    .iAddr      (iAddr),
    .oData      (oData),
    .TFT_RS     (TFT_RS),
    .TFT_CS_N   (TFT_CS_N),
    .TFT_WR_N   (TFT_WR_N),
    .TFT_RD_N   (TFT_RD_N),
    .TFT_DB_OUT (TFT_DB_OUT),
    .TFT_DB_OE  (TFT_DB_OE),
    .TFT_DB_IN  (TFT_DB_IN)
  );

  always #10 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_pins"}, {28'd0, TFT_RS, TFT_CS_N, TFT_WR_N, TFT_RD_N}, 32'hF);
    check({tag, "_oe"},   {31'd0, TFT_DB_OE}, 32'd0);
    check({tag, "_dbout"}, {16'd0, TFT_DB_OUT}, 32'd0);
    check({tag, "_done"}, {31'd0, oDone}, 32'd0);
    check({tag, "_data"}, {16'd0, oData}, 32'd0);
  endtask

  // Runs one transaction and checks its pin timing against the bench's
  // own expectations. exp_lat < 0 means the latency is not checked;
  // abort_at >= 0 drops iCall in that RD_L cycle.
  task automatic run_txn(input string tag, input logic [1:0] call, input logic [7:0] addr,
                         input logic [15:0] din_early, input logic [15:0] din_last,
                         input int exp_lat, input int abort_at,
                         input bit drop_on_done, input bit do_drive);
    int rd_low = 0, idx_l = 0, idx_h = 0, idle_run = 0, turn_seen = -1;
    int oe_viol = 0, done_at = -1, late_done = 0;
    logic [15:0] idx_db = 16'hxxxx;
    logic [15:0] prev_data;
    exp_t e;
    if (do_drive) begin
      iCall = call;
      iAddr = addr;
    end
    TFT_DB_IN = din_early;
    prev_data = oData;
    if (abort_at < 0) sb.push_back('{data: din_last, lat: exp_lat});
    for (int s = 1; s <= 200; s++) begin
      @(negedge CLOCK);
      if (TFT_DB_OE && !TFT_RD_N) oe_viol++;
      if (!TFT_RS && !TFT_CS_N) begin
        idx_l++;
        idx_db = TFT_DB_OUT;
      end
      if (TFT_CS_N && !TFT_WR_N) idx_h++;
      if (!TFT_RD_N) begin
        rd_low++;
        if (rd_low == 1) turn_seen = idle_run;
      end else if (rd_low == 0) begin
        if (TFT_CS_N && TFT_WR_N && !TFT_DB_OE) idle_run++;
        else idle_run = 0;
      end
      if (rd_low == 25) TFT_DB_IN = din_last;
      if (abort_at >= 0 && rd_low == abort_at + 1) begin
        iCall = 2'b00;
        @(negedge CLOCK);
        check({tag, "_abort_csrd"}, {30'd0, TFT_CS_N, TFT_RD_N}, 32'h3);
        check({tag, "_abort_done"}, {31'd0, oDone}, 32'd0);
        check({tag, "_abort_data"}, {16'd0, oData}, {16'd0, prev_data});
        for (int k = 0; k < 60; k++) begin
          @(negedge CLOCK);
          if (oDone) late_done++;
        end
        check({tag, "_abort_nodone"}, late_done, 0);
        $display("txn %s: aborted in RD_L cycle %0d, oData=%h", tag, abort_at, oData);
        return;
      end
      if (oDone) begin
        done_at = s;
        break;
      end
    end
    check({tag, "_done_seen"}, {31'd0, (done_at > 0)}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_data"}, {16'd0, oData}, {16'd0, e.data});
      if (e.lat >= 0) check({tag, "_latency"}, done_at - 1, e.lat);
    end
    check({tag, "_idx_l"}, idx_l, call[1] ? 3 : 0);
    check({tag, "_idx_h"}, idx_h, call[1] ? 25 : 0);
    if (call[1]) check({tag, "_idx_db"}, {16'd0, idx_db}, {24'd0, addr});
    check({tag, "_rd_low"}, rd_low, 25);
    if (do_drive) check({tag, "_turn"}, turn_seen, 2);
    else check({tag, "_turn_min"}, {31'd0, (turn_seen >= 2)}, 32'd1);
    check({tag, "_oe_rd"}, oe_viol, 0);
    if (drop_on_done) iCall = 2'b00;
    @(negedge CLOCK);
    check({tag, "_done_pulse"}, {31'd0, oDone}, 32'd0);
    $display("txn %s: call=%b addr=%h oData=%h latency=%0d rd_low=%0d", tag, call, addr, oData, done_at - 1, rd_low);
  endtask

  initial begin
    int waited;
    // Power-on reset.
    RESET = 1'b1;
    repeat (3) @(negedge CLOCK);
    check_reset_pins("por");
    $display("txn por: reset values sampled");
    RESET = 1'b0;
    @(negedge CLOCK);

    // Index write + read, index 0x00.
    run_txn("idx00", 2'b10, 8'h00, 16'h9325, 16'h9325, 80, -1, 1'b1, 1'b1);
    repeat (2) @(negedge CLOCK);
    // Read only.
    run_txn("rd",    2'b01, 8'h00, 16'hF800, 16'hF800, 52, -1, 1'b1, 1'b1);
    repeat (2) @(negedge CLOCK);
    // Both bits set: index path has priority.
    run_txn("both",  2'b11, 8'h22, 16'h7E57, 16'h7E57, 80, -1, 1'b1, 1'b1);
    repeat (2) @(negedge CLOCK);
    // Bus changes on the final strobe cycle only.
    run_txn("late",  2'b01, 8'h00, 16'h1111, 16'hABCD, 52, -1, 1'b1, 1'b1);
    repeat (2) @(negedge CLOCK);
    // Abort in RD_L cycle 10; oData must keep 0xABCD.
    run_txn("abort", 2'b01, 8'h00, 16'h5555, 16'h5555, -1, 10, 1'b1, 1'b1);
    // Clean transaction after the abort.
    run_txn("again", 2'b01, 8'h00, 16'h0F0F, 16'h0F0F, 52, -1, 1'b1, 1'b1);
    repeat (2) @(negedge CLOCK);
    // Hold iCall past oDone: a second read follows automatically.
    run_txn("hold1", 2'b01, 8'h00, 16'h1234, 16'h1234, 52, -1, 1'b0, 1'b1);
    run_txn("hold2", 2'b01, 8'h00, 16'h4321, 16'h4321, -1, -1, 1'b1, 1'b0);
    repeat (2) @(negedge CLOCK);

    // Reset mid-RD_L for two cycles.
    iCall = 2'b01;
    TFT_DB_IN = 16'hDEAD;
    waited = 0;
    while (TFT_RD_N && waited < 100) begin
      @(negedge CLOCK);
      waited++;
    end
    check("rst_reach_rdl", {31'd0, (waited < 100)}, 32'd1);
    repeat (5) @(negedge CLOCK);
    RESET = 1'b1;
    iCall = 2'b00;
    @(negedge CLOCK);
    check_reset_pins("rst1");
    @(negedge CLOCK);
    check_reset_pins("rst2");
    $display("txn rst: reset mid-read, oData=%h", oData);
    RESET = 1'b0;
    @(negedge CLOCK);

    // Clean index transaction after reset.
    run_txn("post",  2'b10, 8'h5A, 16'hBEEF, 16'hBEEF, 80, -1, 1'b1, 1'b1);
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL timeout compared=%0d", n_cmp);
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "time limit");
  end

endmodule
